// File: rtl/vga_timing_decoder_pkg.sv
// Shared types and default geometry for the VGA timing decoder.
package vga_timing_decoder_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/vga_timing_decoder_edge_det.sv
// Falling-edge detector on an active-low sync/enable line; history idles high.
module vga_timing_decoder_edge_det (
    input  logic clk,
    input  logic rst_ni,
    input  logic sig,
    output logic fall
);
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) prev <= 1'b1;
        else         prev <= sig;
    end

    assign fall = prev & ~sig;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers active-pixel coordinates, frame/line strobes and measured geometry from a
// VGA vs/hs/blank stream, and tracks lock against the expected active geometry.
module vga_timing_decoder
    import vga_timing_decoder_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2,
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   vs_ni,
    input  logic                   hs_ni,
    input  logic                   blank_ni,
    input  logic [PIXEL_DEPTH-1:0] input_R,
    input  logic [PIXEL_DEPTH-1:0] input_G,
    input  logic [PIXEL_DEPTH-1:0] input_B,
    output logic                   de_o,
    output logic [CNT_W-1:0]       col_o,
    output logic [CNT_W-1:0]       row_o,
    output logic                   sof_o,
    output logic                   eol_o,
    output logic [PIXEL_DEPTH-1:0] output_R,
    output logic [PIXEL_DEPTH-1:0] output_G,
    output logic [PIXEL_DEPTH-1:0] output_B,
    output logic [CNT_W-1:0]       line_len_o,
    output logic [CNT_W-1:0]       frame_lines_o,
    output logic                   locked_o,
    output logic                   err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP    = CNT_W'(V_ACTIVE);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic vs_fall, hs_fall, blank_fall;

    vga_timing_decoder_edge_det u_vs_edge    (.clk(clk), .rst_ni(rst_ni), .sig(vs_ni),    .fall(vs_fall));
    vga_timing_decoder_edge_det u_hs_edge    (.clk(clk), .rst_ni(rst_ni), .sig(hs_ni),    .fall(hs_fall));
    vga_timing_decoder_edge_det u_blank_edge (.clk(clk), .rst_ni(rst_ni), .sig(blank_ni), .fall(blank_fall));

    lock_state_e      state, state_next;
    logic [3:0]       match_cnt, match_next;
    logic             err_next;
    logic [CNT_W-1:0] col_cnt, row_cnt;      // next column; completed active lines in frame
    logic             line_active, frame_ok, sof_pending;

    logic [CNT_W-1:0] col_base, row_base, frame_lines_now;
    logic             line_bad, frame_match;

    // A frame start also ends the current line, and it wins over a coincident line start.
    assign line_bad        = (hs_fall | vs_fall) & line_active & (col_cnt != H_EXP);
    assign frame_lines_now = line_active ? sat_inc(row_cnt) : row_cnt;
    assign frame_match     = frame_ok & ~line_bad & (frame_lines_now == V_EXP);
    assign col_base        = (vs_fall | hs_fall) ? '0 : col_cnt;
    assign row_base        = vs_fall ? '0 : ((hs_fall & line_active) ? sat_inc(row_cnt) : row_cnt);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        match_next = match_cnt;
        err_next   = 1'b0;
        case (state)
            SEARCH: if (vs_fall) begin
                state_next = MEASURE;
                match_next = '0;
            end
            MEASURE: if (vs_fall) begin
                if (frame_match) begin
                    match_next = match_cnt + 4'd1;
                    if (match_cnt + 4'd1 >= LOCK_TGT) state_next = LOCKED;
                end else begin
                    match_next = '0;
                end
            end
            LOCKED: if ((hs_fall & line_bad) | (vs_fall & ~frame_match)) begin
                err_next   = 1'b1;
                state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= SEARCH;
            match_cnt <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_next;
            match_cnt <= match_next;
            err_o     <= err_next;
        end
    end

    assign locked_o = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            de_o          <= 1'b0;
            col_o         <= '0;
            row_o         <= '0;
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            output_R      <= '0;
            output_G      <= '0;
            output_B      <= '0;
            line_len_o    <= '0;
            frame_lines_o <= '0;
            col_cnt       <= '0;
            row_cnt       <= '0;
            line_active   <= 1'b0;
            frame_ok      <= 1'b1;
            sof_pending   <= 1'b0;
        end else begin
            de_o     <= blank_ni;
            output_R <= input_R;
            output_G <= input_G;
            output_B <= input_B;
            sof_o    <= blank_ni & (sof_pending | vs_fall);
            eol_o    <= blank_fall;
            row_cnt  <= row_base;

            // col_o/row_o hold through blanking so eol_o still shows the last pixel's column.
            if (blank_ni) begin
                col_o       <= col_base;
                row_o       <= row_base;
                col_cnt     <= sat_inc(col_base);
                line_active <= 1'b1;
            end else begin
                col_cnt     <= col_base;
                line_active <= line_active & ~(vs_fall | hs_fall);
            end

            if (blank_ni)     sof_pending <= 1'b0;
            else if (vs_fall) sof_pending <= 1'b1;

            if (vs_fall)       frame_ok <= 1'b1;
            else if (line_bad) frame_ok <= 1'b0;

            if (hs_fall & line_active) line_len_o    <= col_cnt;
            if (vs_fall)               frame_lines_o <= frame_lines_now;
        end
    end

endmodule
